// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-bus sequencer: FSM states,
// register index width, requester owner codes and bus register indices.
package reg_bus_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS_DEF = 8;

  localparam logic OWNER_CTRL = 1'b0;
  localparam logic OWNER_DBG  = 1'b1;

  localparam logic [REG_IDX_W-1:0] REG_A   = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_B   = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_C   = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_D   = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_TMP = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_PC  = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_MAR = 3'd6;
  localparam logic [REG_IDX_W-1:0] REG_OUT = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] src;
    logic [REG_IDX_W-1:0] dst;
    logic                 owner;
  } xfer_t;

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Request/handshake and register-select bundle between the two requesters
// (ctrl, dbg) and the sequencer; slave is the sequencer side.
interface reg_bus_sequencer_if;
  import reg_bus_pkg::*;

  logic                 ctrl_valid;
  logic [REG_IDX_W-1:0] ctrl_src;
  logic [REG_IDX_W-1:0] ctrl_dst;
  logic                 ctrl_ready;
  logic                 dbg_valid;
  logic [REG_IDX_W-1:0] dbg_src;
  logic [REG_IDX_W-1:0] dbg_dst;
  logic                 dbg_ready;
  logic                 halt;
  logic [NUM_REGS_DEF-1:0] oe_n;
  logic [NUM_REGS_DEF-1:0] ld_n;
  logic                 busy;
  logic                 done;
  logic                 done_owner;

  modport master (
    output ctrl_valid, ctrl_src, ctrl_dst, dbg_valid, dbg_src, dbg_dst, halt,
    input  ctrl_ready, dbg_ready, oe_n, ld_n, busy, done, done_owner
  );

  modport slave (
    input  ctrl_valid, ctrl_src, ctrl_dst, dbg_valid, dbg_src, dbg_dst, halt,
    output ctrl_ready, dbg_ready, oe_n, ld_n, busy, done, done_owner
  );

endinterface

// File: rtl/reg_bus_sequencer_sel.sv
// Registered active-low one-hot-low select decode with enable; output is
// all ones when disabled or in reset.
module reg_sel_decode #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [N-1:0]     sel_n_o
);

  logic [N-1:0] sel_n_d;
  logic [N-1:0] sel_n_q;

  always_comb begin
    sel_n_d = '1;
    if (en_i) sel_n_d[idx_i] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_n_q <= '1;
    else     sel_n_q <= sel_n_d;
  end

  assign sel_n_o = sel_n_q;

endmodule

// File: rtl/reg_bus_sequencer.sv
// Two-requester register-bus transfer sequencer (IDLE -> DRIVE -> LATCH).
// Define REG_BUS_SEQ_ROUND_ROBIN_EN for round-robin arbitration; default is ctrl-first.
module reg_bus_sequencer
  import reg_bus_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_REGS      = 8
) (
  input  logic                clk,
  input  logic                rst,
  reg_bus_sequencer_if.slave  bus
);

  localparam logic [2:0] CNT_LAST = 3'(SETTLE_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  xfer_t      xfer_q, xfer_d;
  logic       can_grant, grant_ctrl, grant_dbg;
  logic       noop_d, oe_en, ld_en;
  logic [NUM_REGS-1:0] oe_n_w, ld_n_w;

`ifdef REG_BUS_SEQ_ROUND_ROBIN_EN
  // ptr_q names the requester that wins the next tie
  logic ptr_q, ptr_d;

  assign ptr_d = grant_ctrl ? OWNER_DBG : (grant_dbg ? OWNER_CTRL : ptr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= OWNER_CTRL;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    can_grant  = (state_q == IDLE) && !bus.halt && !rst;
`ifdef REG_BUS_SEQ_ROUND_ROBIN_EN
    grant_ctrl = can_grant && bus.ctrl_valid && (!bus.dbg_valid || (ptr_q == OWNER_CTRL));
`else
    grant_ctrl = can_grant && bus.ctrl_valid;
`endif
    grant_dbg  = can_grant && bus.dbg_valid && !grant_ctrl;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer_d  = xfer_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ctrl || grant_dbg) begin
          xfer_d.owner = grant_dbg ? OWNER_DBG : OWNER_CTRL;
          xfer_d.src   = grant_dbg ? bus.dbg_src : bus.ctrl_src;
          xfer_d.dst   = grant_dbg ? bus.dbg_dst : bus.ctrl_dst;
          cnt_d        = '0;
          state_d      = (xfer_d.src == xfer_d.dst) ? LATCH : DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    xfer_q <= xfer_d;
  end

  // Selects are decoded from next state so they line up with the state register
  assign noop_d = (xfer_d.src == xfer_d.dst);
  assign oe_en  = (state_d != IDLE) && !noop_d;
  assign ld_en  = (state_d == LATCH) && !noop_d;

  reg_sel_decode #(.N(NUM_REGS), .IDX_W(REG_IDX_W)) u_oe_dec (
    .clk     (clk),
    .rst     (rst),
    .en_i    (oe_en),
    .idx_i   (xfer_d.src),
    .sel_n_o (oe_n_w)
  );

  reg_sel_decode #(.N(NUM_REGS), .IDX_W(REG_IDX_W)) u_ld_dec (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ld_en),
    .idx_i   (xfer_d.dst),
    .sel_n_o (ld_n_w)
  );

  assign bus.oe_n       = oe_n_w;
  assign bus.ld_n       = ld_n_w;
  assign bus.ctrl_ready = grant_ctrl;
  assign bus.dbg_ready  = grant_dbg;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == LATCH);
  assign bus.done_owner = (state_q == LATCH) && xfer_q.owner;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: two instances (SETTLE_CYCLES 1 and 3) checked
// every cycle against a transaction-level model, plus directed sequences.
module tb_reg_bus_sequencer;
  import reg_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bus_sequencer_if bus0();
  reg_bus_sequencer_if bus1();

  reg_bus_sequencer #(.SETTLE_CYCLES(1), .NUM_REGS(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  reg_bus_sequencer #(.SETTLE_CYCLES(3), .NUM_REGS(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic       cv[2], dv[2], hl[2];
  logic [2:0] cs[2], cd[2], ds[2], dd[2];

  assign bus0.ctrl_valid = cv[0];
  assign bus0.ctrl_src   = cs[0];
  assign bus0.ctrl_dst   = cd[0];
  assign bus0.dbg_valid  = dv[0];
  assign bus0.dbg_src    = ds[0];
  assign bus0.dbg_dst    = dd[0];
  assign bus0.halt       = hl[0];
  assign bus1.ctrl_valid = cv[1];
  assign bus1.ctrl_src   = cs[1];
  assign bus1.ctrl_dst   = cd[1];
  assign bus1.dbg_valid  = dv[1];
  assign bus1.dbg_src    = ds[1];
  assign bus1.dbg_dst    = dd[1];
  assign bus1.halt       = hl[1];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] s_oe[2], s_ld[2];
  logic       s_rc[2], s_rd[2], s_busy[2], s_done[2], s_own[2];

  // Model: one outstanding transfer per instance, described by its handshake
  // cycle window; next tie-winner pointer for round-robin builds.
  int         settle[2] = '{1, 3};
  int         m_end[2];
  logic [2:0] m_src[2], m_dst[2];
  logic       m_own[2];
  logic       m_ptr[2];

  typedef struct {
    logic       is_dbg;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] oe_exp;
    logic [7:0] ld_exp;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic ctrl_wins(int k);
`ifdef REG_BUS_SEQ_ROUND_ROBIN_EN
    return !dv[k] || (m_ptr[k] == 1'b0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [20:0] model_out(int k);
    logic       gc, gd, busy, done, own;
    logic [7:0] oe, ld;
    gc = 1'b0; gd = 1'b0; busy = 1'b0; done = 1'b0; own = 1'b0;
    oe = 8'hFF; ld = 8'hFF;
    if (!rst) begin
      if (cyc <= m_end[k]) begin
        busy = 1'b1;
        done = (cyc == m_end[k]);
        own  = done & m_own[k];
        if (m_src[k] != m_dst[k]) begin
          oe[m_src[k]] = 1'b0;
          if (done) ld[m_dst[k]] = 1'b0;
        end
      end else if (!hl[k]) begin
        gc = cv[k] && ctrl_wins(k);
        gd = dv[k] && !gc;
      end
    end
    return {gc, gd, busy, done, own, oe, ld};
  endfunction

  task automatic sample();
    s_oe[0] = bus0.oe_n;  s_ld[0] = bus0.ld_n;  s_rc[0] = bus0.ctrl_ready; s_rd[0] = bus0.dbg_ready;
    s_busy[0] = bus0.busy; s_done[0] = bus0.done; s_own[0] = bus0.done_owner;
    s_oe[1] = bus1.oe_n;  s_ld[1] = bus1.ld_n;  s_rc[1] = bus1.ctrl_ready; s_rd[1] = bus1.dbg_ready;
    s_busy[1] = bus1.busy; s_done[1] = bus1.done; s_own[1] = bus1.done_owner;
  endtask

  // One clock: compare at the falling edge, then advance model and requesters.
  task automatic step();
    logic [20:0] e[2];
    logic [20:0] a;
    logic        gd;
    @(negedge clk);
    sample();
    for (int k = 0; k < 2; k++) begin
      e[k] = model_out(k);
      a = {s_rc[k], s_rd[k], s_busy[k], s_done[k], s_own[k] & s_done[k], s_oe[k], s_ld[k]};
      n_cmp++;
      if (a !== e[k]) begin
        n_bad++;
        $display("FAIL cycle_check dut%0d cyc=%0d: got rc,rd,busy,done,own=%b%b%b%b%b oe=%h ld=%h want %b%b%b%b%b oe=%h ld=%h",
                 k, cyc, a[20], a[19], a[18], a[17], a[16], a[15:8], a[7:0],
                 e[k][20], e[k][19], e[k][18], e[k][17], e[k][16], e[k][15:8], e[k][7:0]);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_end[k] = -1;
        m_ptr[k] = 1'b0;
      end else if (e[k][20] || e[k][19]) begin
        gd       = e[k][19];
        m_own[k] = gd;
        m_src[k] = gd ? ds[k] : cs[k];
        m_dst[k] = gd ? dd[k] : cd[k];
        m_end[k] = (m_src[k] == m_dst[k]) ? cyc + 1 : cyc + settle[k] + 1;
        m_ptr[k] = !gd;
        if (gd) dv[k] = 1'b0;
        else    cv[k] = 1'b0;
      end
    end
    cyc++;
  endtask

  vec_t tbl[6];
  int   ord[6];
  int   exp_ord[6];
  int   n, nc, nd;
  logic ld_seen;

  initial begin
    for (int k = 0; k < 2; k++) begin
      cv[k] = 0; dv[k] = 0; hl[k] = 0;
      cs[k] = 0; cd[k] = 0; ds[k] = 0; dd[k] = 0;
      m_end[k] = -1; m_ptr[k] = 0; m_src[k] = 0; m_dst[k] = 0; m_own[k] = 0;
    end
    tbl[0] = '{1'b0, 3'd1, 3'd4, 8'hFD, 8'hEF, 2};
    tbl[1] = '{1'b1, 3'd3, 3'd3, 8'hFF, 8'hFF, 1};
    tbl[2] = '{1'b0, 3'd0, 3'd7, 8'hFE, 8'h7F, 2};
    tbl[3] = '{1'b1, 3'd6, 3'd2, 8'hBF, 8'hFB, 2};
    tbl[4] = '{1'b0, 3'd5, 3'd5, 8'hFF, 8'hFF, 1};
    tbl[5] = '{1'b1, 3'd7, 3'd0, 8'h7F, 8'hFE, 2};

    // Reset state
    step(); step();
    chk("rst_oe0", bus0.oe_n, 8'hFF);
    chk("rst_ld0", bus0.ld_n, 8'hFF);
    chk("rst_busy0", bus0.busy, 0);
    chk("rst_done0", bus0.done, 0);
    chk("rst_oe1", bus1.oe_n, 8'hFF);
    rst = 0;
    step();

    // Reset asserted in the first DRIVE cycle
    cv[0] = 1; cs[0] = 3'd2; cd[0] = 3'd5;
    step();
    chk("mid_rst_ready", s_rc[0], 1);
    rst = 1;
    #1;
    chk("mid_rst_oe", bus0.oe_n, 8'hFF);
    chk("mid_rst_ld", bus0.ld_n, 8'hFF);
    chk("mid_rst_busy", bus0.busy, 0);
    ld_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (s_ld[0] != 8'hFF) ld_seen = 1;
    end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (s_ld[0] != 8'hFF) ld_seen = 1;
    end
    chk("mid_rst_no_load", ld_seen, 0);

    // Single transfers on the SETTLE_CYCLES=1 instance
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].is_dbg) begin dv[0] = 1; ds[0] = tbl[r].src; dd[0] = tbl[r].dst; end
      else               begin cv[0] = 1; cs[0] = tbl[r].src; cd[0] = tbl[r].dst; end
      for (int i = 0; i <= tbl[r].lat; i++) begin
        step();
        if (i == 0) chk($sformatf("row%0d_ready", r), tbl[r].is_dbg ? s_rd[0] : s_rc[0], 1);
        if (i >= 1) chk($sformatf("row%0d_oe_c%0d", r, i), s_oe[0], tbl[r].oe_exp);
        if (i == tbl[r].lat) begin
          chk($sformatf("row%0d_ld", r), s_ld[0], tbl[r].ld_exp);
          chk($sformatf("row%0d_done", r), s_done[0], 1);
          chk($sformatf("row%0d_owner", r), s_own[0], tbl[r].is_dbg);
        end else begin
          chk($sformatf("row%0d_ld_early_c%0d", r, i), s_ld[0], 8'hFF);
          chk($sformatf("row%0d_done_early_c%0d", r, i), s_done[0], 0);
        end
      end
    end

    // Contention: three transfers from each requester
    for (int i = 0; i < 6; i++) ord[i] = 2;
`ifdef REG_BUS_SEQ_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 1, 1, 1};
`endif
    n = 0; nc = 0; nd = 0;
    cv[0] = 1; cs[0] = 3'd1; cd[0] = 3'd2;
    dv[0] = 1; ds[0] = 3'd3; dd[0] = 3'd4;
    for (int t = 0; t < 60 && n < 6; t++) begin
      step();
      if (s_rc[0]) begin ord[n] = 0; n++; nc++; end
      else if (s_rd[0]) begin ord[n] = 1; n++; nd++; end
      if (!cv[0] && nc < 3) cv[0] = 1;
      if (!dv[0] && nd < 3) dv[0] = 1;
    end
    for (int i = 0; i < 6; i++) chk($sformatf("contend_grant%0d", i), ord[i], exp_ord[i]);
    cv[0] = 0; dv[0] = 0;
    for (int i = 0; i < 4; i++) step();

    // halt blocks grants while idle
    hl[0] = 1; cv[0] = 1; cs[0] = 3'd2; cd[0] = 3'd6;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("halt_ready_c%0d", i), s_rc[0], 0);
      chk($sformatf("halt_busy_c%0d", i), s_busy[0], 0);
    end
    hl[0] = 0;
    step();
    chk("halt_release_grant", s_rc[0], 1);
    for (int i = 0; i < 3; i++) step();

    // halt raised mid-flight on the SETTLE_CYCLES=3 instance
    cv[1] = 1; cs[1] = 3'd0; cd[1] = 3'd6;
    step();
    chk("flight_ready", s_rc[1], 1);
    hl[1] = 1; dv[1] = 1; ds[1] = 3'd4; dd[1] = 3'd1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("flight_no_grant_c%0d", i), s_rd[1], 0);
      if (i <= 3) chk($sformatf("flight_oe_c%0d", i), s_oe[1], 8'hFE);
      if (i == 4) begin
        chk("flight_done", s_done[1], 1);
        chk("flight_ld", s_ld[1], 8'hBF);
      end
      if (i >= 5) chk($sformatf("flight_idle_c%0d", i), s_busy[1], 0);
    end
    hl[1] = 0;
    step();
    chk("flight_grant_after_halt", s_rd[1], 1);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic, checked every cycle by the model
    for (int t = 0; t < 800; t++) begin
      for (int k = 0; k < 2; k++) begin
        if (!cv[k] && $urandom_range(0, 2) == 0) begin
          cv[k] = 1;
          cs[k] = 3'($urandom_range(0, 7));
          cd[k] = ($urandom_range(0, 3) == 0) ? cs[k] : 3'($urandom_range(0, 7));
        end
        if (!dv[k] && $urandom_range(0, 2) == 0) begin
          dv[k] = 1;
          ds[k] = 3'($urandom_range(0, 7));
          dd[k] = ($urandom_range(0, 3) == 0) ? ds[k] : 3'($urandom_range(0, 7));
        end
        hl[k] = ($urandom_range(0, 7) == 0);
      end
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 0;
    for (int k = 0; k < 2; k++) begin cv[k] = 0; dv[k] = 0; hl[k] = 0; end
    for (int i = 0; i < 10; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
